// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - start/busy/done handshake and HI/LO result bundle of the multiply/divide unit
interface muldiv_unit_if #(
    parameter int n = 32
);
    logic         start;
    logic [1:0]   op;
    logic [n-1:0] a;
    logic [n-1:0] b;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [n-1:0] hi;
    logic [n-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit holding HI/LO; MULDIV_FAST_MULT_EN selects a single-step multiply
module muldiv_unit #(
    parameter int n = 32
) (
    input logic          clk,
    input logic          reset_n,
    muldiv_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
    localparam int cw = $clog2(n + 1);

    state_t         state;
    logic [cw-1:0]  cnt;
    logic           is_div;
    logic           neg_q;
    logic           neg_r;
    logic           b_zero;
    logic [n-1:0]   a_orig;
    logic [n-1:0]   opnd;
    logic [n:0]     rem;
    logic [2*n-1:0] acc;
    logic           busy;
    logic           done;
    logic           div_by_zero;
    logic [n-1:0]   hi;
    logic [n-1:0]   lo;

    logic           a_neg;
    logic           b_neg;
    logic [n-1:0]   mag_a;
    logic [n-1:0]   mag_b;
    logic [n:0]     mul_sum;
    logic [n+1:0]   div_shift;
    logic [n+1:0]   div_diff;
    logic [2*n-1:0] prod_fix;

    // Magnitudes are unsigned n-bit values, so -2^(n-1) maps to 2^(n-1) without overflow.
    assign a_neg = bus.op[0] & bus.a[n-1];
    assign b_neg = bus.op[0] & bus.b[n-1];
    assign mag_a = a_neg ? -bus.a : bus.a;
    assign mag_b = b_neg ? -bus.b : bus.b;

    assign mul_sum   = {1'b0, acc[2*n-1:n]} + (acc[0] ? {1'b0, opnd} : '0);
    assign div_shift = {rem, acc[n-1]};
    assign div_diff  = div_shift - {2'b00, opnd};
    assign prod_fix  = neg_q ? -acc : acc;

`ifdef MULDIV_FAST_MULT_EN
    logic [2*n-1:0] fast_prod;
    assign fast_prod = {{n{a_neg}}, bus.a} * {{n{b_neg}}, bus.b};
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            is_div      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            b_zero      <= 1'b0;
            a_orig      <= '0;
            opnd        <= '0;
            rem         <= '0;
            acc         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (bus.start) begin
`ifdef MULDIV_FAST_MULT_EN
                        if (!bus.op[1]) begin
                            {hi, lo} <= fast_prod;
                            done     <= 1'b1;
                            state    <= DONE;
                        end else
`endif
                        begin
                            is_div <= bus.op[1];
                            neg_q  <= a_neg ^ b_neg;
                            neg_r  <= a_neg;
                            b_zero <= (bus.b == '0);
                            a_orig <= bus.a;
                            opnd   <= bus.op[1] ? mag_b : mag_a;
                            acc    <= {{n{1'b0}}, (bus.op[1] ? mag_a : mag_b)};
                            rem    <= '0;
                            cnt    <= cw'(n);
                            busy   <= 1'b1;
                            state  <= RUN;
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt - cw'(1);
                    if (is_div) begin
                        // Restoring step: keep the subtraction only when it did not borrow.
                        if (!div_diff[n+1]) begin
                            rem          <= div_diff[n:0];
                            acc[n-1:0]   <= {acc[n-2:0], 1'b1};
                        end else begin
                            rem          <= div_shift[n:0];
                            acc[n-1:0]   <= {acc[n-2:0], 1'b0};
                        end
                    end else begin
                        acc <= {mul_sum, acc[n-1:1]};
                    end
                    if (cnt == cw'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (is_div) begin
                        if (b_zero) begin
                            lo          <= '1;
                            hi          <= a_orig;
                            div_by_zero <= 1'b1;
                        end else begin
                            lo <= neg_q ? -acc[n-1:0] : acc[n-1:0];
                            hi <= neg_r ? -rem[n-1:0] : rem[n-1:0];
                        end
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.div_by_zero = div_by_zero;
    assign bus.hi          = hi;
    assign bus.lo          = lo;
endmodule
